// File: rtl/pe_array_seq_pkg.sv
// Shared types and constants for the PE array sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_MM    = 2'b00,
    MODE_FPMUL = 2'b10,
    MODE_FPADD = 2'b11
  } mode_e;

  // Encoding 01 is reserved; commands carrying it are dropped with an error pulse.
  localparam logic [1:0] MODE_ILLEGAL = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Per-row control bundle: {mode_sel[1:0], y_sel, psu_clr, sys_buf_en}.
  localparam int CTRL_W = 5;

  // Cycles needed after the last feed beat for the wavefront to leave the
  // PE pipeline and reach the bottom row.
  function automatic int flush_len(input int pipe_lat, input int rows);
    return pipe_lat + rows - 1;
  endfunction

endpackage

// File: rtl/pe_array_seq_if.sv
// Command channel from the tile scheduler to the PE array sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the scheduler holds the command while cmd_ready is low.
interface pe_array_seq_if #(
  parameter int KW = 16
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [KW-1:0] cmd_k;
  logic          cmd_ysel;

  modport master (
    output cmd_valid, cmd_mode, cmd_k, cmd_ysel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_k, cmd_ysel,
    output cmd_ready
  );
endinterface

// File: rtl/pe_array_seq_skew.sv
// Per-row control skew: row r sees the row-0 bundle delayed by r cycles.
// Latency: row 0 is combinational pass-through, row r is r flops deep (ROWS >= 2).
// Backpressure: none; the line shifts every cycle.
module ctrl_skew_line #(
  parameter int W    = 5,
  parameter int ROWS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             i_din,
  output logic [ROWS-1:0][W-1:0]   o_tap
);

  logic [ROWS-1:1][W-1:0] r_tap;

  // Shift the row-0 bundle down one row per cycle, clearing the whole line on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tap <= '0;
    end else begin
      r_tap[1] <= i_din;
      for (int r = 2; r < ROWS; r++) begin
        r_tap[r] <= r_tap[r-1];
      end
    end
  end

  assign o_tap = {r_tap, i_din};

endmodule

// File: rtl/pe_array_seq.sv
// Sequencer for a ROWS x COLS PE array: CLEAR/MAC/FLUSH/DRAIN/DONE per command, row-skewed controls.
// Latency: accept->row-0 controls next cycle; row r lags row 0 by r cycles; drain_valid lags row ROWS-1 by 1.
// Backpressure: cmd_ready only in IDLE; a pending command is held off, never dropped (illegal mode excepted).
module pe_array_seq
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int KW       = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_array_seq_if.slave        cmd_if,
  output logic                 feed_en,
  output logic [ROWS-1:0][1:0] mode_sel_o,
  output logic [ROWS-1:0]      psu_clr_o,
  output logic [ROWS-1:0]      sys_buf_en_o,
  output logic [ROWS-1:0]      y_sel_o,
  output logic                 drain_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [KW-1:0] FLUSH_CNT = KW'(flush_len(PIPE_LAT, ROWS));
  localparam logic [KW-1:0] DRAIN_CNT = KW'(ROWS);

  state_e                      r_state;
  logic [KW-1:0]               r_cnt;
  mode_e                       r_mode;
  logic                        r_ysel;
  logic                        r_err;
  logic                        r_drain_valid;
  logic [CTRL_W-1:0]           w_row0;
  logic [ROWS-1:0][CTRL_W-1:0] w_tap;

  assign cmd_if.cmd_ready = (r_state == ST_IDLE);

  // Command FSM: one down-counter is reused for K, flush and drain lengths.
  // mode/ysel stay latched through IDLE so the fp datapath never sees a glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_MM;
      r_ysel  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_if.cmd_valid) begin
            if (cmd_if.cmd_mode == MODE_ILLEGAL) begin
              r_err <= 1'b1;
            end else begin
              r_mode <= mode_e'(cmd_if.cmd_mode);
              r_ysel <= cmd_if.cmd_ysel;
              r_cnt  <= cmd_if.cmd_k;
              if (cmd_if.cmd_mode == MODE_MM) begin
                r_state <= ST_CLEAR;
              end else if (cmd_if.cmd_k != '0) begin
                r_state <= ST_MAC;
              end else begin
                r_state <= ST_FLUSH;
                r_cnt   <= FLUSH_CNT;
              end
            end
          end
        end
        ST_CLEAR: begin
          // Counter still holds K from accept; K=0 goes straight to flush.
          if (r_cnt == '0) begin
            r_state <= ST_FLUSH;
            r_cnt   <= FLUSH_CNT;
          end else begin
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_cnt == KW'(1)) begin
            r_state <= ST_FLUSH;
            r_cnt   <= FLUSH_CNT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == KW'(1)) begin
            if (r_mode == MODE_MM) begin
              r_state <= ST_DRAIN;
              r_cnt   <= DRAIN_CNT;
            end else begin
              r_state <= ST_DONE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == KW'(1)) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Row-0 control bundle is a pure decode of the registered state and latched command.
  always_comb begin
    w_row0 = {r_mode, r_ysel, (r_state == ST_CLEAR), (r_state == ST_DRAIN)};
  end

  ctrl_skew_line #(
    .W    (CTRL_W),
    .ROWS (ROWS)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .i_din (w_row0),
    .o_tap (w_tap)
  );

  // Fan the skewed bundles out to the per-row control ports.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      mode_sel_o[r]   = w_tap[r][4:3];
      y_sel_o[r]      = w_tap[r][2];
      psu_clr_o[r]    = w_tap[r][1];
      sys_buf_en_o[r] = w_tap[r][0];
    end
  end

  // Bottom-edge results are registered, so valid trails the last row's drain enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_valid <= 1'b0;
    end else begin
      r_drain_valid <= sys_buf_en_o[ROWS-1];
    end
  end

  assign feed_en     = (r_state == ST_MAC);
  assign done        = (r_state == ST_DONE);
  assign err         = r_err;
  assign drain_valid = r_drain_valid;
  assign busy        = (r_state != ST_IDLE) | (|psu_clr_o) | (|sys_buf_en_o);

endmodule
